// File: rtl/flatten_buffer.sv
// flatten_buffer: collects ROWS binarized feature-map rows (COLS bits each),
// one row per beat, into a single flat ROWS*COLS-bit vector and hands it to
// the final dense layer over a valid/ready handshake.
// Bit r*COLS+c of data_out is pixel (r,c).
// Build option: define FLATTEN_DBUF_EN for a ping-pong (two-bank) buffer that
// sustains one row per cycle; left undefined, a single bank is used with a
// LOAD/HOLD state machine.
module flatten_buffer #(
    parameter int ROWS = 14,
    parameter int COLS = 14,
    localparam int NUM_INPUTS = ROWS * COLS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic                  row_sof,
    input  logic [COLS-1:0]       row_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_INPUTS-1:0] data_out,
    output logic                  sync_err
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0] slot;
    logic             sync_err_q, sync_err_d;
    logic             row_accept;
    logic             out_accept;
    logic             frame_done;

    assign row_accept = row_valid & row_ready;
    assign out_accept = out_valid & out_ready;
    assign sync_err   = sync_err_q;

    // Returns vec with the row at slot idx replaced by data.
    function automatic logic [NUM_INPUTS-1:0] put_row(
        input logic [NUM_INPUTS-1:0] vec,
        input logic [CNT_W-1:0]      idx,
        input logic [COLS-1:0]       data
    );
        logic [NUM_INPUTS-1:0] res;
        res = vec;
        for (int r = 0; r < ROWS; r++) begin
            if (idx == CNT_W'(r)) begin
                res[r*COLS +: COLS] = data;
            end
        end
        return res;
    endfunction

    // Row framing: pick the slot for the accepted beat, advance the counter,
    // and flag a mid-frame restart (the partial frame is abandoned and the
    // sof beat becomes row 0 of the new frame).
    always_comb begin
        row_cnt_d  = row_cnt_q;
        sync_err_d = sync_err_q;
        slot       = row_cnt_q;
        frame_done = 1'b0;
        if (row_accept) begin
            if (row_sof) begin
                slot      = '0;
                row_cnt_d = CNT_W'(1);
                if (row_cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end else if (row_cnt_q == LAST_ROW) begin
                row_cnt_d  = '0;
                frame_done = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + 1'b1;
            end
        end
    end

    // Framing registers; sync_err is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_cnt_q  <= '0;
            sync_err_q <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            sync_err_q <= sync_err_d;
        end
    end

`ifdef FLATTEN_DBUF_EN

    logic [1:0][NUM_INPUTS-1:0] bank_q, bank_d;
    logic [1:0]                 full_q, full_d;
    logic                       wr_bank_q, wr_bank_d;
    logic                       rd_bank_q, rd_bank_d;

    assign row_ready = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign data_out  = bank_q[rd_bank_q];

    // Ping-pong control: a completed frame flips the write bank, a consume
    // flips the read bank; a row write can never target the bank being
    // consumed, so both events may land on the same edge.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (row_accept) begin
            bank_d[wr_bank_q] = put_row(bank_q[wr_bank_q], slot, row_data);
        end
        if (out_accept) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (frame_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    // Bank storage and pointers; reset discards everything buffered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_q    <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

`else

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_INPUTS-1:0] bank_q, bank_d;

    assign row_ready = (state_q == LOAD);
    assign out_valid = (state_q == HOLD);
    assign data_out  = bank_q;

    // Single bank: fill during LOAD, present during HOLD until consumed.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        if (row_accept) begin
            bank_d = put_row(bank_q, slot, row_data);
        end
        if (state_q == LOAD) begin
            if (frame_done) begin
                state_d = HOLD;
            end
        end else begin
            if (out_accept) begin
                state_d = LOAD;
            end
        end
    end

    // State and bank registers; reset discards any partial or held frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
        end
    end

`endif

endmodule

// File: tb/tb_flatten_buffer.sv
// tb_flatten_buffer: directed bench for flatten_buffer with a frame
// scoreboard. Expected frames are queued as rows are driven and popped by a
// monitor whenever the DUT hands a frame downstream.
module tb_flatten_buffer;

   localparam int ROWS = 14;
   localparam int COLS = 14;
   localparam int NI   = ROWS * COLS;

   logic            clock = 1'b0;
   logic            reset;
   logic            row_valid;
   logic            row_ready;
   logic            row_sof;
   logic [COLS-1:0] row_data;
   logic            out_valid;
   logic            out_ready;
   logic [NI-1:0]   data_out;
   logic            sync_err;

   logic [NI-1:0]   exp_q[$];
   int              vectors = 0;
   int              miscompares = 0;

   // Free-running clock, posedges at 5, 15, 25, ...
   always #5 clock = ~clock;

   flatten_buffer #(.ROWS(ROWS), .COLS(COLS)) dut (
      .clock    (clock),
      .reset    (reset),
      .row_valid(row_valid),
      .row_ready(row_ready),
      .row_sof  (row_sof),
      .row_data (row_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .data_out (data_out),
      .sync_err (sync_err)
   );

   // Single comparison point: counts, asserts, reports.
   task automatic checkOutput(input string tag, input logic [NI-1:0] observed,
                              input logic [NI-1:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drives one row beat and holds it until accepted (bounded).
   task automatic applyStimulus(input logic sof, input logic [COLS-1:0] data);
      bit done;
      done      = 1'b0;
      row_valid = 1'b1;
      row_sof   = sof;
      row_data  = data;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (row_ready) done = 1'b1;
         @(posedge clock);
         #1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $error("[TB] FAIL row_accept_timeout observed=stalled expected=accepted");
      end
      row_valid = 1'b0;
      row_sof   = 1'b0;
   endtask

   // Consumes every pending frame, then confirms the scoreboard drained.
   task automatic drainOutputs(input string tag);
      bit done;
      done      = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clock);
         if (!out_valid && exp_q.size() == 0) done = 1'b1;
      end
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      checkOutput(tag, exp_q.size(), 0);
      checkOutput({tag, "_valid_low"}, out_valid, 1'b0);
   endtask

   // Scoreboard monitor: a frame handed over on the coming edge must match
   // the oldest expected frame.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL unexpected_frame observed=%h expected=none", data_out);
         end else begin
            checkOutput("frame_data", data_out, exp_q.pop_front());
         end
      end
   end

   // Hard stop if the sequence ever wedges.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [NI-1:0]   f1;
      logic [NI-1:0]   f2;
      logic [NI-1:0]   fy;
      logic [COLS-1:0] rd;

      reset     = 1'b1;
      row_valid = 1'b0;
      row_sof   = 1'b0;
      row_data  = '0;
      out_ready = 1'b0;
      #12;
      checkOutput("rst_out_valid", out_valid, 1'b0);
      checkOutput("rst_row_ready", row_ready, 1'b1);
      checkOutput("rst_data_out", data_out, '0);
      checkOutput("rst_sync_err", sync_err, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Step 1: diagonal frame, latency of one cycle after the last row.
      $display("[TB] step 1: diagonal frame");
      f1 = '0;
      for (int r = 0; r < ROWS; r++) f1[r*COLS + (r % COLS)] = 1'b1;
      exp_q.push_back(f1);
      for (int r = 0; r < ROWS; r++) begin
         rd = '0;
         rd[r % COLS] = 1'b1;
         if (r == ROWS - 1) checkOutput("s1_valid_before_last", out_valid, 1'b0);
         applyStimulus(r == 0, rd);
      end
      @(negedge clock);
      checkOutput("s1_out_valid", out_valid, 1'b1);
      checkOutput("s1_data_out", data_out, f1);
      checkOutput("s1_sync_err", sync_err, 1'b0);
      @(posedge clock);
      #1;

      // Step 2: downstream stalls for 20 cycles.
      $display("[TB] step 2: output back-pressure");
`ifdef FLATTEN_DBUF_EN
      f2 = '0;
      for (int r = 0; r < ROWS; r++) begin
         rd = COLS'(r * 613 + 5);
         f2[r*COLS +: COLS] = rd;
         applyStimulus(r == 0, rd);
      end
      exp_q.push_back(f2);
`else
      f2 = '0;
`endif
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checkOutput("s2_hold_valid", out_valid, 1'b1);
         checkOutput("s2_hold_data", data_out, f1);
         checkOutput("s2_row_ready", row_ready, 1'b0);
         @(posedge clock);
         #1;
      end
      drainOutputs("s2_drain");

      // Step 3: sof arrives mid-frame; only the restarted frame is output.
      $display("[TB] step 3: mid-frame restart");
      exp_q.push_back('0);
      for (int r = 0; r < 5; r++) applyStimulus(r == 0, 14'h3FFF);
      checkOutput("s3_sync_err_clear", sync_err, 1'b0);
      applyStimulus(1'b1, 14'h0000);
      checkOutput("s3_sync_err_set", sync_err, 1'b1);
      for (int r = 1; r < ROWS; r++) applyStimulus(1'b0, 14'h0000);
      @(negedge clock);
      checkOutput("s3_out_valid", out_valid, 1'b1);
      checkOutput("s3_data_out", data_out, '0);
      checkOutput("s3_sync_err", sync_err, 1'b1);
      @(posedge clock);
      #1;
      drainOutputs("s3_drain");

`ifdef FLATTEN_DBUF_EN
      // Step 4: three frames back-to-back with no bubbles.
      $display("[TB] step 4: back-to-back frames");
      exp_q.push_back({NI{1'b1}});
      exp_q.push_back('0);
      f2 = '0;
      for (int r = 0; r < ROWS; r++) f2[r*COLS +: COLS] = 14'h2AAA;
      exp_q.push_back(f2);
      out_ready = 1'b1;
      for (int k = 1; k <= 44; k++) begin
         if (k <= 3 * ROWS) begin
            row_valid = 1'b1;
            row_sof   = ((k - 1) % ROWS) == 0;
            row_data  = (k <= ROWS) ? 14'h3FFF : (k <= 2 * ROWS) ? 14'h0000 : 14'h2AAA;
         end else begin
            row_valid = 1'b0;
            row_sof   = 1'b0;
         end
         @(negedge clock);
         if (k <= 3 * ROWS) checkOutput("s4_row_ready", row_ready, 1'b1);
         checkOutput("s4_out_valid", out_valid, (k == 15 || k == 29 || k == 43));
         @(posedge clock);
         #1;
      end
      out_ready = 1'b0;
      checkOutput("s4_all_frames", exp_q.size(), 0);
`endif

      // Step 5: reset while a frame is held; nothing stale survives.
      $display("[TB] step 5: reset mid-stream");
      for (int r = 0; r < ROWS; r++) applyStimulus(r == 0, 14'h3FFF);
`ifdef FLATTEN_DBUF_EN
      for (int r = 0; r < 7; r++) applyStimulus(r == 0, 14'h3FFF);
`endif
      checkOutput("s5_valid_before_reset", out_valid, 1'b1);
      reset = 1'b1;
      #2;
      checkOutput("s5_rst_out_valid", out_valid, 1'b0);
      checkOutput("s5_rst_data_out", data_out, '0);
      checkOutput("s5_rst_row_ready", row_ready, 1'b1);
      checkOutput("s5_rst_sync_err", sync_err, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      f2 = '0;
      for (int r = 0; r < ROWS; r++) f2[r*COLS +: COLS] = COLS'(r * 1171 + 9) & 14'h1555;
      exp_q.push_back(f2);
      for (int r = 0; r < ROWS; r++) applyStimulus(r == 0, COLS'(r * 1171 + 9) & 14'h1555);
      @(negedge clock);
      checkOutput("s5_out_valid", out_valid, 1'b1);
      checkOutput("s5_data_out", data_out, f2);
      @(posedge clock);
      #1;
      drainOutputs("s5_drain");

      // Step 6: consume coincides with the last row of the next frame.
      $display("[TB] step 6: consume on last-row cycle");
      fy = '0;
      for (int r = 0; r < ROWS; r++) fy[r*COLS +: COLS] = COLS'(14'h0F0F ^ (r * 97));
`ifdef FLATTEN_DBUF_EN
      f2 = '0;
      for (int r = 0; r < ROWS; r++) f2[r*COLS +: COLS] = COLS'(r + 1);
      exp_q.push_back(f2);
      for (int r = 0; r < ROWS; r++) applyStimulus(r == 0, COLS'(r + 1));
`endif
      exp_q.push_back(fy);
      for (int r = 0; r < ROWS; r++) begin
         if (r == ROWS - 1) out_ready = 1'b1;
         applyStimulus(r == 0, COLS'(14'h0F0F ^ (r * 97)));
      end
      out_ready = 1'b0;
      checkOutput("s6_out_valid", out_valid, 1'b1);
      checkOutput("s6_data_out", data_out, fy);
      drainOutputs("s6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
